layer1_conv_sequencer: RTL and testbench

- Sequences the layer-1 convolution datapath once the bus-write controller has filled the local pixel, weight and bias memories.
- Preloads 216 weights and 8 biases into the PE array, then streams 27-tap input windows (3 ch x 3x3) for every output position.
- Counts returned results and raises the completion interrupt.
- Sits between the store controller/local memories and the PE array.

---
 rtl/layer1_conv_sequencer_if.sv | 47 ++++
 rtl/layer1_conv_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_layer1_conv_sequencer.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/layer1_conv_sequencer_if.sv
// Signal bundle between layer1_conv_sequencer, its local memories/store controller and the PE array.
interface layer1_conv_sequencer_if #(
    parameter int ADDR_W = 16
);
    logic              start;
    logic              layer1_input_store_done;
    logic              layer1_weight_store_done;
    logic              layer1_bias_store_done;
    logic              pe_ready;
    logic              result_valid;
    logic              read_weight_mem;
    logic [ADDR_W-1:0] weight_mem_addr;
    logic              read_bias_mem;
    logic [ADDR_W-1:0] bias_mem_addr;
    logic              read_pixel_mem;
    logic [ADDR_W-1:0] pixel_mem_addr;
    logic              weight_load_valid;
    logic [7:0]        weight_load_idx;
    logic              bias_load_valid;
    logic [2:0]        bias_load_idx;
    logic              pix_valid;
    logic              pix_last;
    logic [4:0]        pix_tap_idx;
    logic              pix_zero;
    logic [ADDR_W-1:0] out_pos;
    logic              busy;
    logic              layer1_done;
    logic              irq_set;

    modport master (
        input  start, layer1_input_store_done, layer1_weight_store_done,
               layer1_bias_store_done, pe_ready, result_valid,
        output read_weight_mem, weight_mem_addr, read_bias_mem, bias_mem_addr,
               read_pixel_mem, pixel_mem_addr, weight_load_valid, weight_load_idx,
               bias_load_valid, bias_load_idx, pix_valid, pix_last, pix_tap_idx,
               pix_zero, out_pos, busy, layer1_done, irq_set
    );

    modport slave (
        output start, layer1_input_store_done, layer1_weight_store_done,
               layer1_bias_store_done, pe_ready, result_valid,
        input  read_weight_mem, weight_mem_addr, read_bias_mem, bias_mem_addr,
               read_pixel_mem, pixel_mem_addr, weight_load_valid, weight_load_idx,
               bias_load_valid, bias_load_idx, pix_valid, pix_last, pix_tap_idx,
               pix_zero, out_pos, busy, layer1_done, irq_set
    );
endinterface

// File: rtl/layer1_conv_sequencer.sv
// Layer-1 conv sequencer: preloads weights/biases, streams 27-tap windows, counts results, raises irq.
// Build option LAYER1_ZERO_PAD_EN selects pad-1 "same" convolution; default is valid convolution.
module layer1_conv_sequencer #(
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32,
    parameter int IN_CH  = 3,
    parameter int OUT_CH = 8,
    parameter int K      = 3,
    parameter int ADDR_W = 16
) (
    input logic                     clk,
    input logic                     rst,
    layer1_conv_sequencer_if.master bus
);
`ifdef LAYER1_ZERO_PAD_EN
    localparam int OUT_W = IMG_W;
    localparam int OUT_H = IMG_H;
`else
    localparam int OUT_W = IMG_W - K + 1;
    localparam int OUT_H = IMG_H - K + 1;
`endif
    localparam logic [7:0]        W_LAST  = 8'(OUT_CH * IN_CH * K * K - 1);
    localparam logic [2:0]        B_LAST  = 3'(OUT_CH - 1);
    localparam logic [ADDR_W-1:0] TOTAL   = ADDR_W'(OUT_W * OUT_H);
    localparam logic [ADDR_W-1:0] IMG_W_A = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] PLANE_A = ADDR_W'(IMG_W * IMG_H);
    localparam logic [ADDR_W-1:0] OUT_W_A = ADDR_W'(OUT_W);
    localparam logic [ADDR_W-1:0] K_A     = ADDR_W'(K);
    localparam logic [ADDR_W-1:0] KK_A    = ADDR_W'(K * K);

    typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_B, CONV, DRAIN, DONE} state_t;
    state_t state_q, state_d;

    logic [7:0]        wcnt;
    logic [2:0]        bcnt;
    logic [ADDR_W-1:0] oy, ox, ch, ky, kx, result_cnt;
    logic [ADDR_W-1:0] src_y, src_x, pix_addr, pos;
    logic [4:0]        tap;
    logic              rd_w, rd_b, issue, in_bounds;
    logic              kx_end, ky_end, ch_end, ox_end, win_end, img_end;

    logic              weight_load_valid_p1, bias_load_valid_p1, pix_valid_p1, pix_last_p1, irq_p1;
    logic [7:0]        weight_load_idx_p1;
    logic [2:0]        bias_load_idx_p1;
    logic [4:0]        pix_tap_idx_p1;
    logic [ADDR_W-1:0] out_pos_p1;
`ifdef LAYER1_ZERO_PAD_EN
    logic              pix_zero_p1;
`endif

    always_comb begin
        kx_end  = (kx == K_A - 1'b1);
        ky_end  = (ky == K_A - 1'b1);
        ch_end  = (ch == ADDR_W'(IN_CH - 1));
        ox_end  = (ox == ADDR_W'(OUT_W - 1));
        win_end = kx_end && ky_end && ch_end;
        img_end = win_end && ox_end && (oy == ADDR_W'(OUT_H - 1));
        src_y   = oy + ky;
        src_x   = ox + kx;
`ifdef LAYER1_ZERO_PAD_EN
        // src_* carry a +1 pad offset: row/col 0 and IMG_*+1 fall outside the image
        in_bounds = (src_y != '0) && (src_y <= ADDR_W'(IMG_H)) && (src_x != '0) && (src_x <= IMG_W_A);
        pix_addr  = ch * PLANE_A + (src_y - 1'b1) * IMG_W_A + (src_x - 1'b1);
`else
        in_bounds = 1'b1;
        pix_addr  = ch * PLANE_A + src_y * IMG_W_A + src_x;
`endif
        pos = oy * OUT_W_A + ox;
        tap = 5'(ch * KK_A + ky * K_A + kx);
    end

    always_comb begin
        state_d = state_q;
        rd_w    = 1'b0;
        rd_b    = 1'b0;
        issue   = 1'b0;
        case (state_q)
            IDLE:    if (bus.start && bus.layer1_input_store_done && bus.layer1_weight_store_done &&
                         bus.layer1_bias_store_done) state_d = LOAD_W;
            LOAD_W:  begin
                rd_w = 1'b1;
                if (wcnt == W_LAST) state_d = LOAD_B;
            end
            LOAD_B:  begin
                rd_b = 1'b1;
                if (bcnt == B_LAST) state_d = CONV;
            end
            CONV:    begin
                issue = bus.pe_ready;
                if (issue && img_end) state_d = DRAIN;
            end
            DRAIN:   if (result_cnt == TOTAL) state_d = DONE;
            DONE:    if (!bus.start) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt <= '0; bcnt <= '0; result_cnt <= '0;
            oy <= '0; ox <= '0; ch <= '0; ky <= '0; kx <= '0;
        end else if (state_q == IDLE) begin
            wcnt <= '0; bcnt <= '0; result_cnt <= '0;
            oy <= '0; ox <= '0; ch <= '0; ky <= '0; kx <= '0;
        end else begin
            if (rd_w) wcnt <= (wcnt == W_LAST) ? '0 : wcnt + 1'b1;
            if (rd_b) bcnt <= (bcnt == B_LAST) ? '0 : bcnt + 1'b1;
            // kx fastest, oy slowest
            if (issue) begin
                kx <= kx_end ? '0 : kx + 1'b1;
                if (kx_end) begin
                    ky <= ky_end ? '0 : ky + 1'b1;
                    if (ky_end) begin
                        ch <= ch_end ? '0 : ch + 1'b1;
                        if (ch_end) begin
                            ox <= ox_end ? '0 : ox + 1'b1;
                            if (ox_end) oy <= oy + 1'b1;
                        end
                    end
                end
            end
            if ((state_q == CONV || state_q == DRAIN) && bus.result_valid)
                result_cnt <= result_cnt + 1'b1;
        end
    end

    // ---- stage p1: tags aligned with one-cycle memory read data ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            weight_load_valid_p1 <= 1'b0; weight_load_idx_p1 <= '0;
            bias_load_valid_p1   <= 1'b0; bias_load_idx_p1   <= '0;
            pix_valid_p1 <= 1'b0; pix_last_p1 <= 1'b0; pix_tap_idx_p1 <= '0;
            out_pos_p1   <= '0;   irq_p1      <= 1'b0;
`ifdef LAYER1_ZERO_PAD_EN
            pix_zero_p1  <= 1'b0;
`endif
        end else begin
            weight_load_valid_p1 <= rd_w;
            weight_load_idx_p1   <= rd_w ? wcnt : '0;
            bias_load_valid_p1   <= rd_b;
            bias_load_idx_p1     <= rd_b ? bcnt : '0;
            pix_valid_p1         <= issue;
            pix_last_p1          <= issue && win_end;
            pix_tap_idx_p1       <= issue ? tap : '0;
            if (issue)                 out_pos_p1 <= pos;
            else if (state_q == IDLE)  out_pos_p1 <= '0;
            irq_p1 <= (state_q == DRAIN) && (state_d == DONE);
`ifdef LAYER1_ZERO_PAD_EN
            pix_zero_p1 <= issue && !in_bounds;
`endif
        end
    end

    assign bus.read_weight_mem   = rd_w;
    assign bus.weight_mem_addr   = ADDR_W'(wcnt);
    assign bus.read_bias_mem     = rd_b;
    assign bus.bias_mem_addr     = ADDR_W'(bcnt);
    assign bus.read_pixel_mem    = issue && in_bounds;
    assign bus.pixel_mem_addr    = (state_q == CONV) ? pix_addr : '0;
    assign bus.weight_load_valid = weight_load_valid_p1;
    assign bus.weight_load_idx   = weight_load_idx_p1;
    assign bus.bias_load_valid   = bias_load_valid_p1;
    assign bus.bias_load_idx     = bias_load_idx_p1;
    assign bus.pix_valid         = pix_valid_p1;
    assign bus.pix_last          = pix_last_p1;
    assign bus.pix_tap_idx       = pix_tap_idx_p1;
`ifdef LAYER1_ZERO_PAD_EN
    assign bus.pix_zero          = pix_zero_p1;
`else
    assign bus.pix_zero          = 1'b0;
`endif
    assign bus.out_pos           = out_pos_p1;
    assign bus.busy              = (state_q == LOAD_W) || (state_q == LOAD_B) ||
                                   (state_q == CONV)   || (state_q == DRAIN);
    assign bus.layer1_done       = (state_q == DONE);
    assign bus.irq_set           = irq_p1;
endmodule

// File: tb/tb_layer1_conv_sequencer.sv
// Randomized bench for layer1_conv_sequencer against a window-enumeration reference model.
// Honors LAYER1_ZERO_PAD_EN the same way as the design.
module tb_layer1_conv_sequencer;
    localparam int IMG_W = 32, IMG_H = 32, IN_CH = 3, K = 3;
`ifdef LAYER1_ZERO_PAD_EN
    localparam int PAD = 1;
`else
    localparam int PAD = 0;
`endif
    localparam int OXN = IMG_W - K + 1 + 2 * PAD;
    localparam int OYN = IMG_H - K + 1 + 2 * PAD;
    localparam int NPOS = OXN * OYN;

    typedef struct {
        int tap;
        bit last;
        bit zero;
        int pos;
    } tap_t;

    logic clk = 1'b0;
    logic rst;
    layer1_conv_sequencer_if #(.ADDR_W(16)) bus ();

    layer1_conv_sequencer dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;
    tap_t tap_q[$];
    int rd_q[$];
    int due_q[$];
    int cyc = 0;
    bit pe_mode = 1'b0;
    bit mon_en = 1'b0;
    int wexp, bexp, ri, vi, n_last, n_irq, first_rd, last_rd;
    logic [26:0] zmask;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic build_model();
        tap_t e;
        tap_q.delete();
        rd_q.delete();
        for (int oy = 0; oy < OYN; oy++)
            for (int ox = 0; ox < OXN; ox++)
                for (int c = 0; c < IN_CH; c++)
                    for (int ky = 0; ky < K; ky++)
                        for (int kx = 0; kx < K; kx++) begin
                            int y = oy + ky - PAD;
                            int x = ox + kx - PAD;
                            e.tap  = c * 9 + ky * 3 + kx;
                            e.last = (e.tap == 26);
                            e.zero = (y < 0) || (y >= IMG_H) || (x < 0) || (x >= IMG_W);
                            e.pos  = oy * OXN + ox;
                            tap_q.push_back(e);
                            if (!e.zero) rd_q.push_back(c * IMG_W * IMG_H + y * IMG_W + x);
                        end
    endtask

    task automatic clear_model();
        wexp = 0; bexp = 0; ri = 0; vi = 0; n_last = 0; n_irq = 0;
        first_rd = -1; last_rd = -1; zmask = '0;
    endtask

    task automatic check_outs_zero(input string tag);
        check({tag, "_ctl"}, 32'({bus.read_weight_mem, bus.read_bias_mem, bus.read_pixel_mem,
              bus.weight_load_valid, bus.bias_load_valid, bus.pix_valid, bus.pix_last,
              bus.pix_zero, bus.busy, bus.layer1_done, bus.irq_set}), 32'd0);
        check({tag, "_addr"}, 32'(bus.weight_mem_addr | bus.bias_mem_addr |
              bus.pixel_mem_addr | bus.out_pos), 32'd0);
        check({tag, "_idx"}, 32'({bus.weight_load_idx, bus.bias_load_idx, bus.pix_tap_idx}), 32'd0);
    endtask

    task automatic wait_done(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 70000; i++) begin
            @(negedge clk);
            if (bus.layer1_done) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_done"}, 32'(seen), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic end_checks(input string tag);
        check({tag, "_w_cnt"}, wexp, 216);
        check({tag, "_b_cnt"}, bexp, 8);
        check({tag, "_reads"}, ri, rd_q.size());
        check({tag, "_taps"}, vi, tap_q.size());
        check({tag, "_n_last"}, n_last, NPOS);
        check({tag, "_n_irq"}, n_irq, 1);
        check({tag, "_done_hold"}, 32'(bus.layer1_done), 32'd1);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
`ifdef LAYER1_ZERO_PAD_EN
        check({tag, "_pad_mask"}, 32'(zmask), 32'h0013C9E4F);
        check({tag, "_first_rd"}, first_rd, 0);
`else
        check({tag, "_first_rd"}, first_rd, 0);
        check({tag, "_last_rd"}, last_rd, 3071);
`endif
    endtask

    // PE array and pe_ready driver
    initial begin
        bus.pe_ready = 1'b0;
        bus.result_valid = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            bus.pe_ready = pe_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.result_valid = 1'b0;
            if (due_q.size() > 0 && due_q[0] <= cyc) begin
                bus.result_valid = 1'b1;
                void'(due_q.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (bus.weight_load_valid) begin
                check("w_idx", 32'(bus.weight_load_idx), wexp);
                wexp++;
            end
            if (bus.bias_load_valid) begin
                check("b_idx", 32'(bus.bias_load_idx), bexp);
                check("b_after_w", wexp, 216);
                bexp++;
            end
            if (bus.read_pixel_mem) begin
                check("rd_when_ready", 32'(bus.pe_ready), 32'd1);
                if (ri < rd_q.size()) check("rd_addr", 32'(bus.pixel_mem_addr), rd_q[ri]);
                else                  check("rd_extra", ri, rd_q.size());
                if (ri == 0) first_rd = int'(bus.pixel_mem_addr);
                last_rd = int'(bus.pixel_mem_addr);
                ri++;
            end
            if (bus.pix_valid) begin
                if (vi < tap_q.size()) begin
                    check("tap_idx", 32'(bus.pix_tap_idx), tap_q[vi].tap);
                    check("tap_last", 32'(bus.pix_last), 32'(tap_q[vi].last));
                    check("tap_zero", 32'(bus.pix_zero), 32'(tap_q[vi].zero));
                    check("out_pos", 32'(bus.out_pos), tap_q[vi].pos);
                end else begin
                    check("tap_extra", vi, tap_q.size());
                end
                if (vi < 27) zmask[vi] = bus.pix_zero;
                if (bus.pix_last) begin
                    n_last++;
                    due_q.push_back(cyc + 5);
                end
                vi++;
            end
            if (bus.irq_set) n_irq++;
        end
    end

    initial begin
        bit found;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.layer1_input_store_done = 1'b0;
        bus.layer1_weight_store_done = 1'b0;
        bus.layer1_bias_store_done = 1'b0;
        build_model();
        clear_model();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outs_zero("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        bus.start = 1'b1;
        bus.layer1_input_store_done = 1'b1;
        bus.layer1_weight_store_done = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check_outs_zero("idle_hold");
        end
        mon_en = 1'b1;
        @(posedge clk);
        #1 bus.layer1_bias_store_done = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("start_rd_w", 32'(bus.read_weight_mem), 32'd1);
        check("start_w_addr", 32'(bus.weight_mem_addr), 32'd0);

        found = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (bus.pix_valid && bus.out_pos == 16'd100) begin
                found = 1'b1;
                break;
            end
        end
        check("reach_pos100", 32'(found), 32'd1);
        rst = 1'b1;
        #1;
        check_outs_zero("mid_rst");
        check("mid_rst_irq", n_irq, 0);
        due_q.delete();
        clear_model();
        @(posedge clk);
        #1 rst = 1'b0;

        wait_done("nostall");
        end_checks("nostall");
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check_outs_zero("back_idle");

        clear_model();
        pe_mode = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b1;
        wait_done("rand");
        end_checks("rand");
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check_outs_zero("final_idle");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
